// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: RV32I width codes and FSM states.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module lsu_lane_align
    import load_store_unit_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic [2:0]       i_funct3,
    input  logic [1:0]       i_off,
    input  logic [Width-1:0] i_old,
    input  logic [Width-1:0] i_new,
    output logic [Width-1:0] o_load,
    output logic [Width-1:0] o_merge
);

    logic [4:0]  w_bitpos;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_bitpos = {i_off, 3'b000};
    assign w_byte   = i_old[w_bitpos +: 8];
    assign w_half   = i_off[1] ? i_old[31:16] : i_old[15:0];

    always_comb begin
        o_load  = i_old;
        o_merge = i_old;
        unique case (i_funct3)
            F3_B: begin
                o_load = {{(Width-8){w_byte[7]}}, w_byte};
                o_merge[w_bitpos +: 8] = i_new[7:0];
            end
            F3_H: begin
                o_load = {{(Width-16){w_half[15]}}, w_half};
                if (i_off[1])
                    o_merge[31:16] = i_new[15:0];
                else
                    o_merge[15:0] = i_new[15:0];
            end
            F3_W: begin
                o_load  = i_old;
                o_merge = i_new;
            end
            F3_BU: o_load = {{(Width-8){1'b0}}, w_byte};
            F3_HU: o_load = {{(Width-16){1'b0}}, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: checks, reads, merges and writes one request at a time.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int Width = 32,
    parameter int Depth = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             we,
    input  logic [2:0]       funct3,
    input  logic [Width-1:0] addr,
    input  logic [Width-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [Width-1:0] rdata,
    output logic             MemWrite,
    output logic             MemRead,
    output logic [Width-1:0] mem_addr,
    output logic [Width-1:0] WriteData,
    input  logic [Width-1:0] ReadData
);

    state_t           r_state;
    state_t           w_next;
    logic             r_we;
    logic [2:0]       r_f3;
    logic [Width-1:0] r_addr;
    logic [Width-1:0] r_wdata;
    logic [Width-1:0] r_old;
    logic [Width-1:0] r_rdata;
    logic             r_err;

    logic [Width-1:0] w_widx;
    logic [Width-1:0] w_old;
    logic [Width-1:0] w_load;
    logic [Width-1:0] w_merge;
    logic             w_mis;
    logic             w_oor;
    logic             w_err;

    assign w_widx = r_addr >> 2;
    assign w_mis  = ((r_f3[1:0] == 2'b01) && r_addr[0]) ||
                    ((r_f3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
    assign w_oor  = w_widx >= Width'(Depth);
    assign w_err  = !f3_legal(r_we, r_f3) || w_mis || w_oor;

    // Loads extract straight from memory; stores merge into the captured word.
    assign w_old  = r_we ? r_old : ReadData;

    lsu_lane_align #(.Width(Width)) u_align (
        .i_funct3 (r_f3),
        .i_off    (r_addr[1:0]),
        .i_old    (w_old),
        .i_new    (r_wdata),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        WriteData = '0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (req)
                    w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_err)
                    w_next = S_DONE;
                else if (r_we && (r_f3 == F3_W))
                    w_next = S_WR;
                else
                    w_next = S_RD;
            end
            S_RD: begin
                MemRead = 1'b1;
                w_next  = r_we ? S_WR : S_DONE;
            end
            S_WR: begin
                MemWrite  = 1'b1;
                WriteData = w_merge;
                w_next    = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                err    = r_err;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_old   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && req) begin
                r_we    <= we;
                r_f3    <= funct3;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (r_state == S_CHECK)
                r_err <= w_err;
            if (r_state == S_RD) begin
                if (r_we)
                    r_old <= ReadData;
                else
                    r_rdata <= w_load;
            end
        end
    end

    assign mem_addr = w_widx;
    assign rdata    = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a word-array reference model.
module tb_load_store_unit;

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        int          start;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata, mem_addr, WriteData, ReadData;
    logic        MemWrite, MemRead;

    logic [31:0] mem  [512];
    logic [31:0] mmem [512];
    logic        init_mem = 1'b0;
    logic [31:0] last_rd = '0;

    exp_t sb[$];
    exp_t me;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rdc = 0;
    int   wrc = 0;

    load_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .mem_addr  (mem_addr),
        .WriteData (WriteData),
        .ReadData  (ReadData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    assign ReadData = (mem_addr < 32'd512) ? mem[mem_addr[8:0]] : 32'h0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 512; i++) mem[i] <= mmem[i];
        end else if (MemWrite && (mem_addr < 32'd512)) begin
            mem[mem_addr[8:0]] <= WriteData;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input string nm, input logic iwe,
                                   input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd);
        exp_t        e;
        int          sz;
        int          sh;
        int          idx;
        logic        leg;
        logic [31:0] w, m, v;
        leg = iwe ? (f3 <= 3'd2)
                  : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz = 1 << f3[1:0];
        e.name  = nm;
        e.start = 0;
        e.err   = !leg || ((a % 32'(sz)) != 0) || ((a / 4) >= 32'd512);
        e.lat = 2; e.nrd = 0; e.nwr = 0;
        if (!e.err) begin
            idx = int'(a / 4);
            w   = mmem[idx];
            sh  = 8 * int'(a % 4);
            if (!iwe) begin
                v = w >> sh;
                if (sz == 1) begin
                    v = v & 32'hFF;
                    if (f3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
                end else if (sz == 2) begin
                    v = v & 32'hFFFF;
                    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
                end
                last_rd = v;
                e.lat = 3; e.nrd = 1;
            end else begin
                m = (sz == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * sz)) - 1);
                mmem[idx] = (w & ~(m << sh)) | ((wd & m) << sh);
                e.lat = (sz == 4) ? 3 : 4;
                e.nrd = (sz == 4) ? 0 : 1;
                e.nwr = 1;
            end
        end
        e.rdata = last_rd;
        return e;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL idle_wait: busy=%b after %0d cycles", busy, n);
        end
    endtask

    task automatic issue(input string nm, input logic iwe, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        wait_idle();
        e = model(nm, iwe, f3, a, wd);
        e.start = cyc;
        sb.push_back(e);
        req = 1'b1; we = iwe; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            rdc = 0;
            wrc = 0;
        end else begin
            if (MemRead && MemWrite) begin
                total++; bad++;
                $display("FAIL strobes: MemRead=1 MemWrite=1 want exclusive");
            end
            rdc += int'(MemRead);
            wrc += int'(MemWrite);
            if (done) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done want none");
                end else begin
                    me = sb.pop_front();
                    chk({me.name, "_err"}, 32'(err), 32'(me.err));
                    chk({me.name, "_rdata"}, rdata, me.rdata);
                    chk({me.name, "_lat"}, 32'(cyc - me.start), 32'(me.lat));
                    chk({me.name, "_nrd"}, 32'(rdc), 32'(me.nrd));
                    chk({me.name, "_nwr"}, 32'(wrc), 32'(me.nwr));
                end
                rdc = 0;
                wrc = 0;
            end
        end
    end

    initial begin
        int          c0;
        int          n;
        exp_t        e1, e2;
        logic        rw;
        logic [2:0]  f3;
        logic [31:0] a;

        for (int i = 0; i < 512; i++) mmem[i] = 32'h0;
        for (int i = 0; i < 16; i++) mmem[i] = $urandom;
        mmem[4] = 32'h8070F0A5;
        init_mem = 1'b1;
        @(posedge clk);
        #1 init_mem = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_memread", 32'(MemRead), 32'h0);
        chk("rst_memwrite", 32'(MemWrite), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_writedata", WriteData, 32'h0);
        rst_n = 1'b1;

        issue("lb_11", 1'b0, 3'b000, 32'h11, 32'h0);
        issue("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0);
        issue("lh_12", 1'b0, 3'b001, 32'h12, 32'h0);
        issue("sb_12", 1'b1, 3'b000, 32'h12, 32'h000000CC);
        issue("lw_10", 1'b0, 3'b010, 32'h10, 32'h0);
        issue("sw_20", 1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
        issue("lw_20", 1'b0, 3'b010, 32'h20, 32'h0);
        issue("e_lw_06", 1'b0, 3'b010, 32'h06, 32'h0);
        issue("e_sh_03", 1'b1, 3'b001, 32'h03, 32'h1234);
        issue("e_lw_800", 1'b0, 3'b010, 32'h800, 32'h0);
        issue("e_ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0);
        drain();
        chk("word4_after_sb", mem[4], 32'h80CCF0A5);
        chk("word8_after_sw", mem[8], 32'hDEADBEEF);

        for (int i = 0; i < 80; i++) begin
            rw = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a = a & 32'hFFFFFFFC;
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h800;
            issue("rnd", rw, f3, a, $urandom);
        end
        drain();

        // req held high across a whole transaction
        wait_idle();
        c0 = cyc;
        e1 = model("ovl_a", 1'b0, 3'b010, 32'h10, 32'h0);
        e2 = model("ovl_b", 1'b0, 3'b010, 32'h10, 32'h0);
        e1.start = c0;
        e2.start = c0 + 4;
        sb.push_back(e1);
        sb.push_back(e2);
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0;
        drain();
        req = 1'b0;
        repeat (6) @(negedge clk);
        chk("ovl_no_third", 32'(busy), 32'h0);

        // reset during the write phase of a byte store
        wait_idle();
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h15; wdata = 32'h000000EE;
        @(posedge clk);
        #1 req = 1'b0;
        n = 0;
        while (!MemWrite && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wr_reached", 32'(MemWrite), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        last_rd = 32'h0;
        chk("arst_memwrite", 32'(MemWrite), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_writedata", WriteData, 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_word5_kept", mem[5], mmem[5]);
        issue("post_rst_lw", 1'b0, 3'b010, 32'h14, 32'h0);
        drain();

        for (int i = 0; i < 16; i++) chk($sformatf("mem_w%0d", i), mem[i], mmem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
